// File: rtl/block_color_pkg.sv
// Shared types and constants for the block colour accumulator and the colour sorter.
package block_color_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_ACCUM,
    S_DIVIDE,
    S_START,
    S_WAIT_DONE
  } state_e;

  localparam int unsigned GRID     = 4;
  localparam int unsigned N_BLOCKS = GRID * GRID;

  // Channel slice positions within a 24-bit block colour
  localparam int unsigned R_MSB = 23;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

endpackage

// File: rtl/block_window_sum.sv
// Three-channel window accumulator for one grid cell; output is the truncated window mean.
module block_window_sum
  import block_color_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_add,
  input  logic [23:0] i_rgb,
  output logic [23:0] o_avg
);

  localparam int unsigned AW = 8 + 2 * WIN_LOG2;
  localparam int unsigned SH = 2 * WIN_LOG2;

  logic [AW-1:0] r_sum_r, r_sum_g, r_sum_b;
  logic [AW-1:0] w_in_r, w_in_g, w_in_b;

  assign w_in_r = AW'(i_rgb[R_MSB:R_LSB]);
  assign w_in_g = AW'(i_rgb[G_MSB:G_LSB]);
  assign w_in_b = AW'(i_rgb[B_MSB:B_LSB]);

  // A clear cycle may also carry the frame's first pixel, so it seeds rather than zeroes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum_r <= '0;
      r_sum_g <= '0;
      r_sum_b <= '0;
    end else if (i_clear) begin
      r_sum_r <= i_add ? w_in_r : '0;
      r_sum_g <= i_add ? w_in_g : '0;
      r_sum_b <= i_add ? w_in_b : '0;
    end else if (i_add) begin
      r_sum_r <= r_sum_r + w_in_r;
      r_sum_g <= r_sum_g + w_in_g;
      r_sum_b <= r_sum_b + w_in_b;
    end
  end

  assign o_avg = {8'(r_sum_r >> SH), 8'(r_sum_g >> SH), 8'(r_sum_b >> SH)};

endmodule

// File: rtl/block_color_accum.sv
// Samples one frame on request, averages a centred window in each 4x4 grid cell,
// then hands the 16 colours to the sorter and waits for its completion.
module block_color_accum
  import block_color_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_capture,
  input  logic        i_valid,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  input  logic        i_done,
  output logic [23:0] o_block0,
  output logic [23:0] o_block1,
  output logic [23:0] o_block2,
  output logic [23:0] o_block3,
  output logic [23:0] o_block4,
  output logic [23:0] o_block5,
  output logic [23:0] o_block6,
  output logic [23:0] o_block7,
  output logic [23:0] o_block8,
  output logic [23:0] o_block9,
  output logic [23:0] o_block10,
  output logic [23:0] o_block11,
  output logic [23:0] o_block12,
  output logic [23:0] o_block13,
  output logic [23:0] o_block14,
  output logic [23:0] o_block15,
  output logic        o_start,
  output logic        o_busy
);

  localparam int unsigned CW   = H_ACTIVE / GRID;
  localparam int unsigned CH   = V_ACTIVE / GRID;
  localparam int unsigned W    = 1 << WIN_LOG2;
  localparam int unsigned XOFF = (CW - W) / 2;
  localparam int unsigned YOFF = (CH - W) / 2;

  state_e r_state, w_state_next;

  logic [1:0]  w_col, w_row;
  logic [11:0] w_lx, w_ly;
  logic        w_in_range, w_in_win, w_sof, w_eof;
  logic        w_clear, w_divide, w_acc_en;
  logic [3:0]  w_cell;
  logic [23:0] w_rgb;
  logic [23:0] w_avg   [N_BLOCKS];
  logic [23:0] r_block [N_BLOCKS];

  // Cell decode by comparison against multiples of the cell size, avoiding a divider
  always_comb begin
    w_col = 2'd0;
    w_lx  = i_x;
    if (i_x >= 12'(3 * CW)) begin
      w_col = 2'd3;
      w_lx  = i_x - 12'(3 * CW);
    end else if (i_x >= 12'(2 * CW)) begin
      w_col = 2'd2;
      w_lx  = i_x - 12'(2 * CW);
    end else if (i_x >= 12'(CW)) begin
      w_col = 2'd1;
      w_lx  = i_x - 12'(CW);
    end
  end

  always_comb begin
    w_row = 2'd0;
    w_ly  = i_y;
    if (i_y >= 12'(3 * CH)) begin
      w_row = 2'd3;
      w_ly  = i_y - 12'(3 * CH);
    end else if (i_y >= 12'(2 * CH)) begin
      w_row = 2'd2;
      w_ly  = i_y - 12'(2 * CH);
    end else if (i_y >= 12'(CH)) begin
      w_row = 2'd1;
      w_ly  = i_y - 12'(CH);
    end
  end

  assign w_in_range = (i_x < 12'(H_ACTIVE)) && (i_y < 12'(V_ACTIVE));
  assign w_in_win   = (w_lx >= 12'(XOFF)) && (w_lx < 12'(XOFF + W)) &&
                      (w_ly >= 12'(YOFF)) && (w_ly < 12'(YOFF + W));
  assign w_sof      = i_valid && (i_x == 12'd0) && (i_y == 12'd0);
  assign w_eof      = i_valid && (i_x == 12'(H_ACTIVE - 1)) && (i_y == 12'(V_ACTIVE - 1));
  assign w_cell     = {w_row, w_col};
  assign w_rgb      = {i_r, i_g, i_b};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:      if (i_capture) w_state_next = S_WAIT_SOF;
      S_WAIT_SOF:  if (w_sof) w_state_next = S_ACCUM;
      S_ACCUM:     if (w_eof) w_state_next = S_DIVIDE;
      S_DIVIDE:    w_state_next = S_START;
      S_START:     w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_done) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_start  = (r_state == S_START);
    o_busy   = (r_state != S_IDLE);
    w_clear  = (r_state == S_WAIT_SOF);
    w_divide = (r_state == S_DIVIDE);
    w_acc_en = i_valid && w_in_range && w_in_win &&
               ((r_state == S_ACCUM) || ((r_state == S_WAIT_SOF) && w_sof));
  end

  for (genvar g = 0; g < N_BLOCKS; g++) begin : g_cell
    block_window_sum #(
      .WIN_LOG2(WIN_LOG2)
    ) u_sum (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clear(w_clear),
      .i_add  (w_acc_en && (w_cell == 4'(g))),
      .i_rgb  (w_rgb),
      .o_avg  (w_avg[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < N_BLOCKS; n++) r_block[n] <= '0;
    end else if (w_divide) begin
      for (int n = 0; n < N_BLOCKS; n++) r_block[n] <= w_avg[n];
    end
  end

  assign o_block0  = r_block[0];
  assign o_block1  = r_block[1];
  assign o_block2  = r_block[2];
  assign o_block3  = r_block[3];
  assign o_block4  = r_block[4];
  assign o_block5  = r_block[5];
  assign o_block6  = r_block[6];
  assign o_block7  = r_block[7];
  assign o_block8  = r_block[8];
  assign o_block9  = r_block[9];
  assign o_block10 = r_block[10];
  assign o_block11 = r_block[11];
  assign o_block12 = r_block[12];
  assign o_block13 = r_block[13];
  assign o_block14 = r_block[14];
  assign o_block15 = r_block[15];

endmodule

// File: tb/tb_block_color_accum.sv
// Directed bench for block_color_accum on a 64x64 frame with 4x4 windows.
module tb_block_color_accum;

  logic        clk = 1'b0;
  logic        rst, capture, valid, done;
  logic [11:0] x, y;
  logic [7:0]  r, g, b;
  logic [23:0] blk [16];
  logic        start, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  block_color_accum #(
    .H_ACTIVE(64),
    .V_ACTIVE(64),
    .WIN_LOG2(2)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_capture(capture),
    .i_valid  (valid),
    .i_x      (x),
    .i_y      (y),
    .i_r      (r),
    .i_g      (g),
    .i_b      (b),
    .i_done   (done),
    .o_block0 (blk[0]),
    .o_block1 (blk[1]),
    .o_block2 (blk[2]),
    .o_block3 (blk[3]),
    .o_block4 (blk[4]),
    .o_block5 (blk[5]),
    .o_block6 (blk[6]),
    .o_block7 (blk[7]),
    .o_block8 (blk[8]),
    .o_block9 (blk[9]),
    .o_block10(blk[10]),
    .o_block11(blk[11]),
    .o_block12(blk[12]),
    .o_block13(blk[13]),
    .o_block14(blk[14]),
    .o_block15(blk[15]),
    .o_start  (start),
    .o_busy   (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cells are 16x16; the 4x4 window spans local 6..9 on each axis
  function automatic logic [23:0] pix(input int mode, input int px, input int py);
    int lx, ly, n, k;
    bit win;
    lx  = px % 16;
    ly  = py % 16;
    n   = (py / 16) * 4 + (px / 16);
    win = (lx >= 6) && (lx < 10) && (ly >= 6) && (ly < 10);
    case (mode)
      0: return 24'h804020;
      1: begin
        if (!win) return 24'hFFFFFF;
        return {8'(n * 16), 8'(255 - n), 8'(n)};
      end
      2: begin
        if (!(win && n == 0)) return 24'h000000;
        k = (lx - 6) + (ly - 6) * 4;
        return (k % 2 == 0) ? 24'h010101 : 24'h020202;
      end
      default: return 24'h112233;
    endcase
  endfunction

  function automatic logic [23:0] exp_blk(input int mode, input int n);
    case (mode)
      0: return 24'h804020;
      1: return {8'(n * 16), 8'(255 - n), 8'(n)};
      2: return (n == 0) ? 24'h010101 : 24'h000000;
      default: return 24'h112233;
    endcase
  endfunction

  task automatic drive(input int px, input int py, input logic [23:0] c);
    valid = 1'b1;
    x     = 12'(px);
    y     = 12'(py);
    {r, g, b} = c;
  endtask

  // Streams rows 0..last_y-1; optional stalls, out-of-range pixels and stray capture/done pulses
  task automatic send_frame(input int mode, input int last_y, input bit stall, input bit inject,
                            input bit pulses);
    for (int py = 0; py < last_y; py++) begin
      for (int px = 0; px < 64; px++) begin
        if (inject && py == 10 && px == 5) begin
          drive(64, 10, 24'hFFFFFF);
          step();
          drive(10, 64, 24'hFFFFFF);
          step();
        end
        if (stall && px == 7) begin
          valid = 1'b0;
          step();
        end
        if (pulses && py == 20 && px == 0) begin
          capture = 1'b1;
          done    = 1'b1;
        end
        drive(px, py, pix(mode, px, py));
        step();
        capture = 1'b0;
        done    = 1'b0;
      end
    end
    valid = 1'b0;
  endtask

  task automatic do_capture();
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  task automatic finish_wait();
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic check_all(input string tag, input int mode);
    for (int n = 0; n < 16; n++) check_eq($sformatf("%s_blk%0d", tag, n), 32'(blk[n]), 32'(exp_blk(mode, n)));
  endtask

  initial begin
    rst = 1'b1; capture = 1'b0; valid = 1'b0; done = 1'b0;
    x = '0; y = '0; r = '0; g = '0; b = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_start", 32'(start), 32'd0);
    check_eq("rst_blk0", 32'(blk[0]), 32'd0);
    check_eq("rst_blk15", 32'(blk[15]), 32'd0);

    // Uniform frame with stray capture/done during accumulation, plus start timing
    do_capture();
    check_eq("busy_wait_sof", 32'(busy), 32'd1);
    send_frame(0, 64, 1'b0, 1'b0, 1'b1);
    check_eq("start_n", 32'(start), 32'd0);
    step();
    check_eq("start_n1", 32'(start), 32'd1);
    check_eq("blk_n1", 32'(blk[7]), 32'h804020);
    step();
    check_eq("start_n2", 32'(start), 32'd0);
    check_eq("busy_wait_done", 32'(busy), 32'd1);
    check_all("uni", 0);

    // Withheld done, capture ignored while waiting
    capture = 1'b1;
    step();
    capture = 1'b0;
    repeat (100) step();
    check_eq("hold_busy", 32'(busy), 32'd1);
    check_eq("hold_blk5", 32'(blk[5]), 32'h804020);
    finish_wait();
    done = 1'b1;
    step();
    done = 1'b0;
    check_eq("done_in_idle", 32'(busy), 32'd0);

    // Per-cell colours with bright borders, stalls in every row
    do_capture();
    send_frame(1, 64, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    check_all("cell", 1);
    finish_wait();

    // Same frame with out-of-range pixels mixed in
    do_capture();
    send_frame(1, 64, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    check_all("oor", 1);
    finish_wait();

    // Truncating average: 8x1 + 8x2 over 16 pixels
    do_capture();
    send_frame(2, 64, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    check_eq("trunc_blk0", 32'(blk[0]), 32'h010101);
    check_eq("trunc_blk1", 32'(blk[1]), 32'h000000);
    finish_wait();

    // Reset mid-accumulation, then a clean frame
    do_capture();
    send_frame(1, 40, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_blk0", 32'(blk[0]), 32'd0);
    check_eq("abort_blk10", 32'(blk[10]), 32'd0);
    rst = 1'b0;
    step();
    check_eq("abort_idle", 32'(busy), 32'd0);
    do_capture();
    send_frame(3, 64, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    check_all("after_rst", 3);
    finish_wait();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
